// File: rtl/sort_pkg.sv
// Shared sizing helpers for the rank sorter: stage count, rank/count widths
// and the packed element offset used to slice the N*DATA_W sample bus.
package sort_pkg;

  function automatic int unsigned f_lat(input int unsigned n, input int unsigned ppr);
    return (n + ppr - 1) / ppr;
  endfunction

  function automatic int unsigned f_rw(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned f_cw(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

  // LSB offset of element k on a packed bus of w-bit elements
  function automatic int unsigned f_elem(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rank_sort_pipe_oet_pass.sv
// One odd-even transposition pass: PARITY 0 exchanges pairs (0,1),(2,3)..,
// PARITY 1 exchanges (1,2),(3,4)..; unpaired end elements pass straight through.
module oet_pass
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 9,
  parameter int unsigned PARITY = 0
) (
  input  logic [N*DATA_W-1:0] d_i,
  output logic [N*DATA_W-1:0] d_o
);

  for (genvar k = 0; k < N; k++) begin : g_el
    localparam int unsigned LO = f_elem(k, DATA_W);
    if ((k % 2) == PARITY && (k + 1) < N) begin : g_cx
      localparam int unsigned HI = f_elem(k + 1, DATA_W);
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              swap;
      // equal values are left in place
      always_comb begin
        a    = d_i[LO +: DATA_W];
        b    = d_i[HI +: DATA_W];
        swap = a > b;
      end
      assign d_o[LO +: DATA_W] = swap ? b : a;
      assign d_o[HI +: DATA_W] = swap ? a : b;
    end else if (!(k > 0 && ((k - 1) % 2) == PARITY)) begin : g_thru
      assign d_o[LO +: DATA_W] = d_i[LO +: DATA_W];
    end
  end

endmodule

// File: rtl/rank_sort_pipe.sv
// Pipelined odd-even transposition sorter for filter windows: full ascending
// vector plus a per-set selectable order statistic, with stall and occupancy.
module rank_sort_pipe
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned N              = 9,
  parameter int unsigned PASSES_PER_REG = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            done_i,
  input  logic                                            stall_i,
  input  logic [N*DATA_W-1:0]                             data_i,
  input  logic [f_rw(N)-1:0]                              rank_i,
  output logic                                            done_o,
  output logic [N*DATA_W-1:0]                             sorted_o,
  output logic [DATA_W-1:0]                               rank_o,
  output logic [DATA_W-1:0]                               min_o,
  output logic [DATA_W-1:0]                               mid_o,
  output logic [DATA_W-1:0]                               max_o,
  output logic                                            busy_o,
  output logic [f_cw(f_lat(N, PASSES_PER_REG))-1:0]       count_o
);

  localparam int unsigned LAT  = f_lat(N, PASSES_PER_REG);
  localparam int unsigned RW   = f_rw(N);
  localparam int unsigned CW   = f_cw(LAT);
  localparam int unsigned BW   = N * DATA_W;
  localparam int unsigned MID  = (N - 1) / 2;
  localparam logic [RW-1:0] RMAX = RW'(N - 1);

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int unsigned P0 = s * PASSES_PER_REG;
    localparam int unsigned NP = (P0 + PASSES_PER_REG > N) ? (N - P0) : PASSES_PER_REG;

    logic [BW-1:0] stage_in, data_d, data_q;
    logic [RW-1:0] rank_in, rank_d, rank_q;
    logic          vld_in, vld_d, vld_q;

    if (s == 0) begin : g_head
      always_comb begin
        stage_in = data_i;
        rank_in  = (rank_i > RMAX) ? RMAX : rank_i;
        vld_in   = done_i;
      end
    end else begin : g_link
      always_comb begin
        stage_in = g_stage[s-1].data_q;
        rank_in  = g_stage[s-1].rank_q;
        vld_in   = g_stage[s-1].vld_q;
      end
    end

    // passes P0..P0+NP-1 chained combinationally ahead of this register
    for (genvar j = 0; j < NP; j++) begin : g_pass
      logic [BW-1:0] p_in, p_out;
      if (j == 0) begin : g_first
        always_comb p_in = stage_in;
      end else begin : g_next
        always_comb p_in = g_pass[j-1].p_out;
      end
      oet_pass #(
        .DATA_W (DATA_W),
        .N      (N),
        .PARITY ((P0 + j) % 2)
      ) u_pass (
        .d_i (p_in),
        .d_o (p_out)
      );
    end

    always_comb begin
      data_d = data_q;
      rank_d = rank_q;
      vld_d  = vld_q;
      if (!stall_i) begin
        data_d = g_pass[NP-1].p_out;
        rank_d = rank_in;
        vld_d  = vld_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        rank_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        rank_q <= rank_d;
        vld_q  <= vld_d;
      end
    end
  end

  logic [CW-1:0] count_d, count_q;
  logic          accept, retire;

  always_comb begin
    accept  = done_i & ~stall_i;
    retire  = g_stage[LAT-1].vld_q & ~stall_i;
    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + CW'(1);
    end else if (retire && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  logic [BW-1:0] last_data;
  logic [RW-1:0] last_rank;

  always_comb begin
    last_data = g_stage[LAT-1].data_q;
    last_rank = g_stage[LAT-1].rank_q;
    done_o    = g_stage[LAT-1].vld_q;
    sorted_o  = last_data;
    rank_o    = last_data[32'(last_rank) * DATA_W +: DATA_W];
    min_o     = last_data[0 +: DATA_W];
    mid_o     = last_data[MID * DATA_W +: DATA_W];
    max_o     = last_data[(N - 1) * DATA_W +: DATA_W];
    busy_o    = (count_q != '0);
    count_o   = count_q;
  end

endmodule

// File: tb/tb_rank_sort_pipe.sv
// Directed and random checks of rank_sort_pipe (N=9 main, N=25/81 with 3 passes per stage).
module tb_rank_sort_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, done_i, stall_i;
  logic [71:0] data_i;
  logic [3:0]  rank_i;
  logic        done_o, busy_o;
  logic [71:0] sorted_o;
  logic [7:0]  rank_o, min_o, mid_o, max_o;
  logic [3:0]  count_o;

  logic         b_done, b_stall;
  logic [199:0] d25;
  logic [4:0]   r25;
  logic         o25_done, o25_busy;
  logic [199:0] o25_sorted;
  logic [7:0]   o25_rank, o25_min, o25_mid, o25_max;
  logic [3:0]   o25_cnt;
  logic [647:0] d81;
  logic [6:0]   r81;
  logic         o81_done, o81_busy;
  logic [647:0] o81_sorted;
  logic [7:0]   o81_rank, o81_min, o81_mid, o81_max;
  logic [4:0]   o81_cnt;

  rank_sort_pipe #(.DATA_W(8), .N(9), .PASSES_PER_REG(1)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .stall_i(stall_i), .data_i(data_i), .rank_i(rank_i),
    .done_o(done_o), .sorted_o(sorted_o), .rank_o(rank_o), .min_o(min_o), .mid_o(mid_o),
    .max_o(max_o), .busy_o(busy_o), .count_o(count_o)
  );

  rank_sort_pipe #(.DATA_W(8), .N(25), .PASSES_PER_REG(3)) dut25 (
    .clk(clk), .rst(rst), .done_i(b_done), .stall_i(b_stall), .data_i(d25), .rank_i(r25),
    .done_o(o25_done), .sorted_o(o25_sorted), .rank_o(o25_rank), .min_o(o25_min), .mid_o(o25_mid),
    .max_o(o25_max), .busy_o(o25_busy), .count_o(o25_cnt)
  );

  rank_sort_pipe #(.DATA_W(8), .N(81), .PASSES_PER_REG(3)) dut81 (
    .clk(clk), .rst(rst), .done_i(b_done), .stall_i(b_stall), .data_i(d81), .rank_i(r81),
    .done_o(o81_done), .sorted_o(o81_sorted), .rank_o(o81_rank), .min_o(o81_min), .mid_o(o81_mid),
    .max_o(o81_max), .busy_o(o81_busy), .count_o(o81_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [647:0] got, input logic [647:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [647:0] ref_sort(input logic [647:0] v, input int n);
    logic [7:0]   a[81];
    logic [7:0]   t;
    logic [647:0] r;
    int           j;
    for (int i = 0; i < n; i++) a[i] = v[i*8 +: 8];
    for (int i = 1; i < n; i++) begin
      t = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > t) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  typedef struct {
    logic [71:0] srt;
    logic [7:0]  rk;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [647:0] srt;
    int           cyc;
  } big_t;

  exp_t sb[$];
  big_t q25[$];
  big_t q81[$];
  int   cyc = 0;
  int   last_lat = 0;
  int   done_seen = 0;
  int   run = 0;
  int   max_run = 0;
  int   peak = 0;

  task automatic step();
    logic held;
    exp_t e;
    held = stall_i | rst;
    @(posedge clk);
    #1;
    cyc++;
    if (int'(count_o) > peak) peak = int'(count_o);
    if (!held) begin
      if (done_o) begin
        done_seen++;
        run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) begin
          check("unexpected_done", 648'(done_o), '0);
        end else begin
          e = sb.pop_front();
          last_lat = cyc - e.cyc + 1;
          check("sorted", 648'(sorted_o), 648'(e.srt));
          check("rank_o", 648'(rank_o), 648'(e.rk));
          check("min_o", 648'(min_o), 648'(e.srt[7:0]));
          check("mid_o", 648'(mid_o), 648'(e.srt[39:32]));
          check("max_o", 648'(max_o), 648'(e.srt[71:64]));
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic send(input logic [71:0] d, input logic [3:0] r);
    exp_t         e;
    logic [647:0] full;
    int           rc;
    done_i = 1'b1;
    data_i = d;
    rank_i = r;
    if (!stall_i && !rst) begin
      full  = ref_sort(648'(d), 9);
      rc    = (int'(r) > 8) ? 8 : int'(r);
      e.srt = full[71:0];
      e.rk  = full[rc*8 +: 8];
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    step();
    done_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    check(tag, 648'(sb.size()), '0);
  endtask

  function automatic logic [71:0] rnd72();
    logic [71:0] v;
    v[31:0]  = $urandom();
    v[63:32] = $urandom();
    v[71:64] = 8'($urandom());
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [71:0]  s0;
    logic [647:0] v, full;
    big_t         b;
    int           ds, lat25, lat81;

    rst = 1'b1; done_i = 1'b0; stall_i = 1'b0; data_i = '0; rank_i = '0;
    b_done = 1'b0; b_stall = 1'b0; d25 = '0; r25 = '0; d81 = '0; r81 = '0;
    step();
    step();
    check("rst_done", 648'(done_o), '0);
    check("rst_count", 648'(count_o), '0);
    check("rst_sorted", 648'(sorted_o), '0);
    check("rst_busy", 648'(busy_o), '0);
    rst = 1'b0;

    // 1: reversed window, rank 4
    send(72'h010203040506070809, 4'd4);
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check("t1_latency", 648'(last_lat), 648'(9));
    check("t1_sorted", 648'(sorted_o), 648'(72'h090807060504030201));
    check("t1_rank", 648'(rank_o), 648'(8'd5));
    check("t1_min", 648'(min_o), 648'(8'd1));
    check("t1_mid", 648'(mid_o), 648'(8'd5));
    check("t1_max", 648'(max_o), 648'(8'd9));

    // 2: 20 back-to-back random sets
    run = 0; max_run = 0; peak = 0;
    for (int i = 0; i < 20; i++) send(rnd72(), 4'($urandom_range(0, 8)));
    drain("t2_drained");
    check("t2_run", 648'(max_run), 648'(20));
    check("t2_peak", 648'(peak), 648'(9));

    // 3: 3-cycle stall with the pipe full; inputs offered during it must vanish
    full = ref_sort(648'(72'h112233445566778899), 9);
    s0 = full[71:0];
    send(72'h112233445566778899, 4'd0);
    for (int i = 1; i < 9; i++) send(rnd72(), 4'($urandom_range(0, 8)));
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(72'hAAAAAAAAAAAAAAAAAA, 4'd3);
      check("t3_done_held", 648'(done_o), 648'(1'b1));
      check("t3_sorted_held", 648'(sorted_o), 648'(s0));
      check("t3_count_held", 648'(count_o), 648'(9));
    end
    stall_i = 1'b0;
    step();
    check("t3_latency", 648'(last_lat), 648'(12));
    drain("t3_drained");

    // 4: ties and out-of-range rank
    send({9{8'h80}}, 4'd15);
    drain("t4a_drained");
    check("t4a_rank", 648'(rank_o), 648'(8'h80));
    check("t4a_max", 648'(max_o), 648'(8'h80));
    send(72'hFF00FF00FF00FF00FF, 4'd15);
    drain("t4b_drained");
    check("t4b_sorted", 648'(sorted_o), 648'(72'hFFFFFFFFFF00000000));
    check("t4b_rank", 648'(rank_o), 648'(8'hFF));
    check("t4b_mid", 648'(mid_o), 648'(8'hFF));
    send(72'h0000000000000000FF, 4'd15);
    drain("t4c_drained");
    check("t4c_rank", 648'(rank_o), 648'(8'hFF));
    check("t4c_mid", 648'(mid_o), 648'(8'h00));
    check("t4c_min", 648'(min_o), 648'(8'h00));

    // 5: reset with 5 sets in flight
    for (int i = 0; i < 5; i++) send(rnd72(), 4'($urandom_range(0, 8)));
    check("t5_count_pre", 648'(count_o), 648'(5));
    rst = 1'b1;
    step();
    sb.delete();
    check("t5_done", 648'(done_o), '0);
    check("t5_count", 648'(count_o), '0);
    check("t5_busy", 648'(busy_o), '0);
    check("t5_sorted", 648'(sorted_o), '0);
    check("t5_rank", 648'(rank_o), '0);
    rst = 1'b0;
    ds = done_seen;
    repeat (15) step();
    check("t5_no_done", 648'(done_seen - ds), '0);

    // 6: N=25 and N=81, 3 passes per stage, 1000 sets each
    lat25 = -1; lat81 = -1;
    for (int i = 0; i < 1100 && (i < 1000 || q25.size() != 0 || q81.size() != 0); i++) begin
      if (i < 1000) begin
        for (int k = 0; k < 81; k++) v[k*8 +: 8] = 8'($urandom_range(0, (i % 2 == 1) ? 255 : 15));
        b_done = 1'b1;
        d81 = v;
        r81 = 7'($urandom_range(0, 80));
        b.cyc = cyc + 1;
        b.srt = ref_sort(v, 81);
        q81.push_back(b);
        for (int k = 0; k < 81; k++) v[k*8 +: 8] = 8'($urandom_range(0, (i % 3 == 0) ? 7 : 255));
        d25 = v[199:0];
        r25 = 5'($urandom_range(0, 24));
        b.srt = ref_sort(648'(v[199:0]), 25);
        q25.push_back(b);
      end else begin
        b_done = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (o25_done) begin
        if (q25.size() == 0) begin
          check("t6_25_unexpected", 648'(o25_done), '0);
        end else begin
          b = q25.pop_front();
          if (lat25 < 0) lat25 = cyc - b.cyc + 1;
          check("t6_25_sorted", 648'(o25_sorted), b.srt);
        end
      end
      if (o81_done) begin
        if (q81.size() == 0) begin
          check("t6_81_unexpected", 648'(o81_done), '0);
        end else begin
          b = q81.pop_front();
          if (lat81 < 0) lat81 = cyc - b.cyc + 1;
          check("t6_81_sorted", o81_sorted, b.srt);
        end
      end
    end
    b_done = 1'b0;
    check("t6_25_latency", 648'(lat25), 648'(9));
    check("t6_81_latency", 648'(lat81), 648'(27));
    check("t6_25_drained", 648'(q25.size()), '0);
    check("t6_81_drained", 648'(q81.size()), '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
